// File: rtl/riscv_mul_ctrl_if.sv
// rtl/riscv_mul_ctrl_if.sv - pipeline and multiplier signals of the RV64M multiply sequencer
interface riscv_mul_ctrl_if;
    logic        i_riscv_mulctl_req;
    logic [3:0]  i_riscv_mulctl_op;
    logic [63:0] i_riscv_mulctl_rs1;
    logic [63:0] i_riscv_mulctl_rs2;
    logic [4:0]  i_riscv_mulctl_rd;
    logic        i_riscv_mulctl_flush;
    logic        o_riscv_mulctl_stall;
    logic        o_riscv_mulctl_wb;
    logic [63:0] o_riscv_mulctl_result;
    logic [4:0]  o_riscv_mulctl_rd;
    logic        o_riscv_mulctl_timeout;
    logic [63:0] o_riscv_mulctl_mul_rs1data;
    logic [63:0] o_riscv_mulctl_mul_rs2data;
    logic [3:0]  o_riscv_mulctl_mul_mulctrl;
    logic [63:0] i_riscv_mulctl_mul_product;
    logic        i_riscv_mulctl_mul_valid;

    modport slave (
        input  i_riscv_mulctl_req, i_riscv_mulctl_op, i_riscv_mulctl_rs1, i_riscv_mulctl_rs2,
        input  i_riscv_mulctl_rd, i_riscv_mulctl_flush,
        input  i_riscv_mulctl_mul_product, i_riscv_mulctl_mul_valid,
        output o_riscv_mulctl_stall, o_riscv_mulctl_wb, o_riscv_mulctl_result, o_riscv_mulctl_rd,
        output o_riscv_mulctl_timeout,
        output o_riscv_mulctl_mul_rs1data, o_riscv_mulctl_mul_rs2data, o_riscv_mulctl_mul_mulctrl
    );

    modport master (
        output i_riscv_mulctl_req, i_riscv_mulctl_op, i_riscv_mulctl_rs1, i_riscv_mulctl_rs2,
        output i_riscv_mulctl_rd, i_riscv_mulctl_flush,
        output i_riscv_mulctl_mul_product, i_riscv_mulctl_mul_valid,
        input  o_riscv_mulctl_stall, o_riscv_mulctl_wb, o_riscv_mulctl_result, o_riscv_mulctl_rd,
        input  o_riscv_mulctl_timeout,
        input  o_riscv_mulctl_mul_rs1data, o_riscv_mulctl_mul_rs2data, o_riscv_mulctl_mul_mulctrl
    );
endinterface

// File: rtl/riscv_mul_ctrl.sv
// rtl/riscv_mul_ctrl.sv - EX-stage sequencer for the shared multi-cycle RV64M multiplier
// Optional one-entry result cache: RISCV_MULCTL_CACHE_EN
module riscv_mul_ctrl #(
    parameter int TIMEOUT = 80,
    parameter int CNT_W   = 7
) (
    input logic             i_riscv_mul_clk,
    input logic             i_riscv_mul_rst,
    riscv_mul_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q;
    logic [63:0]        rs1_q, rs2_q, result_q;
    logic [4:0]         rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               timeout_q;

    logic               legal, flush, valid, cnt_hit;
    logic               latch, capture, hit_take, set_timeout;
    logic               stall, wb;
    logic [3:0]         mulctrl;
    logic               cache_hit;
    logic [63:0]        cache_prod;

    assign legal   = bus.i_riscv_mulctl_req & bus.i_riscv_mulctl_op[3];
    assign flush   = bus.i_riscv_mulctl_flush;
    assign valid   = bus.i_riscv_mulctl_mul_valid;
    assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        wb          = 1'b0;
        mulctrl     = 4'b0;
        latch       = 1'b0;
        capture     = 1'b0;
        hit_take    = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = legal;
                if (legal && !flush) begin
                    latch    = 1'b1;
                    hit_take = cache_hit;
                    state_d  = cache_hit ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall   = 1'b1;
                mulctrl = op_q;
                if (valid) begin
                    capture = 1'b1;
                    state_d = flush ? S_IDLE : S_DONE;
                end else if (cnt_hit) begin
                    set_timeout = 1'b1;
                    state_d     = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                wb      = !flush;
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                // Keep the multiplier fed until its in-flight product arrives and is dropped.
                stall   = legal;
                mulctrl = op_q;
                if (valid) begin
                    state_d = S_IDLE;
                end else if (cnt_hit) begin
                    set_timeout = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
        if (i_riscv_mul_rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                op_q  <= bus.i_riscv_mulctl_op;
                rs1_q <= bus.i_riscv_mulctl_rs1;
                rs2_q <= bus.i_riscv_mulctl_rs2;
                rd_q  <= bus.i_riscv_mulctl_rd;
            end
            if (capture) begin
                result_q <= bus.i_riscv_mulctl_mul_product;
            end else if (hit_take) begin
                result_q <= cache_prod;
            end
            if (latch) begin
                cnt_q <= '0;
            end else if (state_q == S_BUSY || state_q == S_DRAIN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef RISCV_MULCTL_CACHE_EN
    logic        cache_vld_q;
    logic [3:0]  cache_op_q;
    logic [63:0] cache_rs1_q, cache_rs2_q, cache_prod_q;

    assign cache_hit  = cache_vld_q
                      && cache_op_q  == bus.i_riscv_mulctl_op
                      && cache_rs1_q == bus.i_riscv_mulctl_rs1
                      && cache_rs2_q == bus.i_riscv_mulctl_rs2;
    assign cache_prod = cache_prod_q;

    always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
        if (i_riscv_mul_rst) begin
            cache_vld_q  <= 1'b0;
            cache_op_q   <= '0;
            cache_rs1_q  <= '0;
            cache_rs2_q  <= '0;
            cache_prod_q <= '0;
        end else if (set_timeout) begin
            cache_vld_q <= 1'b0;
        end else if (wb) begin
            cache_vld_q  <= 1'b1;
            cache_op_q   <= op_q;
            cache_rs1_q  <= rs1_q;
            cache_rs2_q  <= rs2_q;
            cache_prod_q <= result_q;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_prod = '0;
`endif

    assign bus.o_riscv_mulctl_stall       = stall;
    assign bus.o_riscv_mulctl_wb          = wb;
    assign bus.o_riscv_mulctl_result      = (state_q == S_DONE) ? result_q : '0;
    assign bus.o_riscv_mulctl_rd          = (state_q == S_DONE) ? rd_q : '0;
    assign bus.o_riscv_mulctl_timeout     = timeout_q;
    assign bus.o_riscv_mulctl_mul_rs1data = rs1_q;
    assign bus.o_riscv_mulctl_mul_rs2data = rs2_q;
    assign bus.o_riscv_mulctl_mul_mulctrl = mulctrl;

endmodule

// File: doc/riscv_mul_ctrl.md
Name: riscv_mul_ctrl

Overview:
- Execute-stage sequencer for the shared multi-cycle RV64M multiplier.
- Accepts one multiply request from the ID/EX pipeline and latches its operands.
- Holds the operands and the multiply control code stable at the multiplier for the whole operation, and stalls the pipeline until the product returns.
- Presents the product for writeback as a one-cycle pulse; absorbs flushes without corrupting the multiplier's state.

Parameters:
- TIMEOUT, 80: max cycles in BUSY/DRAIN without multiplier valid before abort. Must be ≥ 70.
- CNT_W, 7: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_riscv_mul_clk  in  1  clock
- i_riscv_mul_rst  in  1  asynchronous, active-high reset
- i_riscv_mulctl_req  in  1  multiply request valid from EX
- i_riscv_mulctl_op  in  4  op code: 1100 MUL, 1101 MULH, 1110 MULHU, 1111 MULHSU, 1000 MULW
- i_riscv_mulctl_rs1  in  64  operand 1
- i_riscv_mulctl_rs2  in  64  operand 2
- i_riscv_mulctl_rd  in  5  destination register
- i_riscv_mulctl_flush  in  1  kill the in-flight or requesting instruction
- o_riscv_mulctl_stall  out  1  hold the pipeline
- o_riscv_mulctl_wb  out  1  one-cycle writeback strobe
- o_riscv_mulctl_result  out  64  product
- o_riscv_mulctl_rd  out  5  destination register for the writeback
- o_riscv_mulctl_timeout  out  1  sticky watchdog error flag
- o_riscv_mulctl_mul_rs1data  out  64  operand 1 to the multiplier
- o_riscv_mulctl_mul_rs2data  out  64  operand 2 to the multiplier
- o_riscv_mulctl_mul_mulctrl  out  4  control code to the multiplier; bit 3 = start
- i_riscv_mulctl_mul_product  in  64  product from the multiplier
- i_riscv_mulctl_mul_valid  in  1  product valid from the multiplier

Behaviour:
- Reset (async, any state, mid-operation included):
  - state = IDLE.
  - All outputs 0; latched op/rs1/rs2/rd/result = 0.
  - Watchdog counter = 0; timeout flag = 0.
- States: IDLE, BUSY, DONE, DRAIN.
- Legal request: req=1 and op[3]=1. Requests with op[3]=0 are ignored (no stall, no start).
- IDLE:
  - stall = legal request (combinational).
  - Legal request and flush=0: latch op/rs1/rs2/rd; next state BUSY.
  - Legal request and flush=1: nothing latched; stay IDLE.
- BUSY:
  - stall = 1.
  - mul_mulctrl = latched op; mul_rs1data/mul_rs2data = latched operands, held constant every cycle.
  - mul_valid=1: capture mul_product into result; next state DONE (flush=1 in the same cycle → IDLE, no wb).
  - flush=1 without valid: next state DRAIN.
- DONE:
  - wb = !flush; result and rd driven; stall = 0 (the instruction advances this cycle).
  - Next state IDLE unconditionally; req in this cycle is ignored.
- DRAIN:
  - mulctrl and operands stay held; stall = legal request (a new request waits).
  - mul_valid=1: discard the product; next state IDLE, no wb.
- mul_mulctrl = 0 in IDLE and DONE. This guarantees the multiplier never restarts after its valid pulse.
- Operand outputs hold their latched values outside BUSY/DRAIN.
- Watchdog:
  - Counter clears on entry to BUSY; increments each BUSY/DRAIN cycle.
  - Reaching TIMEOUT: timeout flag set (sticky until reset); next state IDLE; no wb.
- Latency: req accepted at T0 → BUSY at T1 → multiplier valid at T67 → wb at T68 (wb = cycle after valid).
- Back-to-back: next request is accepted in the IDLE cycle after DONE.

Optional Feature:
- Macro: RISCV_MULCTL_CACHE_EN
- With the macro defined:
  - One-entry cache of {op, rs1, rs2, product}, written on every DONE with wb=1.
  - A legal, unflushed IDLE request matching the cache exactly goes to DONE at T1 with the cached product; the multiplier is not started.
  - Cache is invalidated on reset and on timeout.
- Without the macro: no cache; every request uses the multiplier.

Test Plan:
- MUL (1100), rs1=7, rs2=-3 → stall T0–T67, wb at T68 only; result 0xFFFFFFFFFFFFFFEB; rd echoed.
- MULHU, rs1=rs2=0xFFFFFFFFFFFFFFFF → result 0xFFFFFFFFFFFFFFFE. MULW, rs1=0x40000000, rs2=2 → result 0xFFFFFFFF80000000.
- Flush at T10 of a MUL → DRAIN; no wb. A new MUL requested at T20 keeps stall high until the drained valid, then completes with a correct result.
- mul_valid held 0 → timeout=1 at T0+TIMEOUT+1; state IDLE; mul_mulctrl=0. Assert reset mid-BUSY → all outputs 0 immediately.
- CACHE_EN: repeat an identical MULH → wb at T1; mul_mulctrl stays 0. Change rs2 by 1 → full latency.
- Request with op=0100 (bit 3 clear) → no stall, mul_mulctrl stays 0, no wb.
